// File: rtl/seletor_quadros_if.sv
// Button/switch inputs and frame outputs of the frame selector, grouped for
// the scanner side (master drives inputs and reads frames, slave is the selector).
interface seletor_quadros_if;
  logic [1:0]  botoes;
  logic        modo_auto;
  logic [2:0]  quadro;
  logic [34:0] padrao;
  logic        novo_quadro;

  modport master (output botoes, modo_auto, input quadro, padrao, novo_quadro);
  modport slave  (input botoes, modo_auto, output quadro, padrao, novo_quadro);
endinterface

// File: rtl/seletor_quadros.sv
// Frame selector for the 7x5 LED matrix: debounced next/previous buttons plus
// an optional auto-play timer step a 3-bit frame index and its registered bitmap.
module seletor_quadros #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int AUTO_PERIOD     = 25000000
) (
  input logic              clock_50MHz,
  input logic              reset,
  seletor_quadros_if.slave bus
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TM_W = (AUTO_PERIOD > 2) ? $clog2(AUTO_PERIOD) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TM_W-1:0] TM_LAST = TM_W'(AUTO_PERIOD - 1);

  typedef enum logic {MANUAL, AUTO} estado_t;

  logic [1:0]      botoes_s1, botoes_s2;
  logic            modo_s1, modo_s2;
  logic [DB_W-1:0] db_cnt [2];
  logic [1:0]      nivel, nivel_d, ev;
  logic            ev_prox, ev_ant;

  estado_t         estado, estado_prox;
  logic [TM_W-1:0] timer;
  logic            tick_auto, limpa_timer;

  logic            avanca, recua;
  logic [2:0]      quadro_r, quadro_prox;
  logic [34:0]     padrao_r;
  logic            novo_r;

  function automatic logic [34:0] padrao_de(input logic [2:0] k);
    if (k == 3'd7) return '1;
    return 35'h1F << (5 * k);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two-stage synchronizer.
  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      botoes_s1 <= '0;
      botoes_s2 <= '0;
      modo_s1   <= 1'b0;
      modo_s2   <= 1'b0;
    end else begin
      botoes_s1 <= bus.botoes;
      botoes_s2 <= botoes_s1;
      modo_s1   <= bus.modo_auto;
      modo_s2   <= modo_s1;
    end
  end

  // A level is accepted only after it differs from the debounced value for
  // DEBOUNCE_CYCLES consecutive cycles; any return to equality restarts the count.
  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
      nivel   <= '0;
      nivel_d <= '0;
    end else begin
      nivel_d <= nivel;
      for (int i = 0; i < 2; i++) begin
        if (botoes_s2[i] == nivel[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          nivel[i]  <= botoes_s2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign ev      = nivel & ~nivel_d;
  assign ev_prox = ev[0];
  assign ev_ant  = ev[1];

  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) estado <= MANUAL;
    else       estado <= estado_prox;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    estado_prox = estado;
    case (estado)
      MANUAL:  if (modo_s2)  estado_prox = AUTO;
      AUTO:    if (!modo_s2) estado_prox = MANUAL;
      default: estado_prox = MANUAL;
    endcase
  end

  always_comb begin
    tick_auto   = 1'b0;
    limpa_timer = 1'b1;
    if (estado == AUTO) begin
      tick_auto   = (timer == TM_LAST);
      limpa_timer = (estado_prox != estado) || tick_auto || (|ev);
    end
  end

  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset)            timer <= '0;
    else if (limpa_timer) timer <= '0;
    else                  timer <= timer + 1'b1;
  end

  // Buttons take priority over the timer tick; opposing buttons cancel.
  assign avanca = (ev_prox & ~ev_ant) | (tick_auto & ~ev_prox & ~ev_ant);
  assign recua  = ev_ant & ~ev_prox;

  always_comb begin
    quadro_prox = quadro_r;
    if (avanca)     quadro_prox = quadro_r + 3'd1;
    else if (recua) quadro_prox = quadro_r - 3'd1;
  end

  always_ff @(posedge clock_50MHz or posedge reset) begin
    if (reset) begin
      quadro_r <= 3'd0;
      padrao_r <= 35'h000_0001F;
      novo_r   <= 1'b0;
    end else begin
      novo_r <= avanca | recua;
      if (avanca | recua) begin
        quadro_r <= quadro_prox;
        padrao_r <= padrao_de(quadro_prox);
      end
    end
  end

  assign bus.quadro      = quadro_r;
  assign bus.padrao      = padrao_r;
  assign bus.novo_quadro = novo_r;

endmodule

// File: tb/tb_seletor_quadros.sv
// Scoreboard bench for seletor_quadros: stimulus pushes expected frames with
// their landing cycle, a negedge monitor pops one per novo_quadro pulse.
module tb_seletor_quadros;

  localparam int DB = 4;
  localparam int AP = 10;
  localparam int LAT = DB + 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  typedef struct {
    logic [2:0]  q;
    logic [34:0] p;
    int          at;
  } exp_t;

  exp_t       sb[$];
  logic [2:0] model_q = 3'd0;

  seletor_quadros_if bus ();

  seletor_quadros #(.DEBOUNCE_CYCLES(DB), .AUTO_PERIOD(AP)) dut (
    .clock_50MHz(clk),
    .reset      (rst),
    .bus        (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [34:0] frame_bits(input logic [2:0] k);
    case (k)
      3'd0: return 35'h0_0000_001F;
      3'd1: return 35'h0_0000_03E0;
      3'd2: return 35'h0_0000_7C00;
      3'd3: return 35'h0_000F_8000;
      3'd4: return 35'h0_01F0_0000;
      3'd5: return 35'h0_3E00_0000;
      3'd6: return 35'h7_C000_0000;
      default: return 35'h7_FFFF_FFFF;
    endcase
  endfunction

  task automatic expect_step(input int dir, input int at);
    exp_t e;
    model_q = model_q + 3'(dir);
    e.q  = model_q;
    e.p  = frame_bits(model_q);
    e.at = at;
    sb.push_back(e);
  endtask

  // Drive a button mask high for hi cycles then low for lo cycles.
  task automatic pulse(input logic [1:0] mask, input int hi, input int lo, input int dir);
    @(negedge clk);
    if (dir != 0) expect_step(dir, cyc + LAT);
    bus.botoes = mask;
    repeat (hi) @(negedge clk);
    bus.botoes = 2'b00;
    repeat (lo) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.novo_quadro === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_novo_quadro", {61'd0, bus.quadro}, 64'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_quadro", {61'd0, bus.quadro}, {61'd0, e.q});
        check("sb_padrao", {29'd0, bus.padrao}, {29'd0, e.p});
        check("sb_cycle", 64'(cyc), 64'(e.at));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bus.botoes    = 2'b00;
    bus.modo_auto = 1'b0;

    // Asynchronous reset mid-cycle, checked before any clock edge.
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_quadro", {61'd0, bus.quadro}, 64'd0);
    check("rst_padrao", {29'd0, bus.padrao}, 64'h1F);
    check("rst_novo", {63'd0, bus.novo_quadro}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("hold_quadro", {61'd0, bus.quadro}, 64'd0);
    check("hold_padrao", {29'd0, bus.padrao}, 64'h1F);
    check("hold_novo", {63'd0, bus.novo_quadro}, 64'd0);

    // Next with wrap 7 -> 0.
    for (int i = 0; i < 8; i++) pulse(2'b01, 8, 8, 1);
    check("next_wrap_quadro", {61'd0, bus.quadro}, 64'd0);

    // Previous with wrap 0 -> 7, then short bounces ignored.
    pulse(2'b10, 8, 8, -1);
    check("prev_wrap_quadro", {61'd0, bus.quadro}, 64'd7);
    check("prev_wrap_padrao", {29'd0, bus.padrao}, 64'h7_FFFF_FFFF);
    for (int i = 0; i < 3; i++) pulse(2'b10, 3, 3, 0);
    repeat (8) @(negedge clk);
    check("bounce_quadro", {61'd0, bus.quadro}, 64'd7);

    // Reach 3, then both buttons together cancel.
    for (int i = 0; i < 4; i++) pulse(2'b01, 8, 8, 1);
    check("at3_quadro", {61'd0, bus.quadro}, 64'd3);
    pulse(2'b11, 8, 8, 0);
    check("both_quadro", {61'd0, bus.quadro}, 64'd3);
    pulse(2'b01, 8, 8, 1);
    check("after_both_quadro", {61'd0, bus.quadro}, 64'd4);

    // Auto-play from 5: ticks land at c0+13, +23, +33.
    pulse(2'b01, 8, 8, 1);
    check("at5_quadro", {61'd0, bus.quadro}, 64'd5);
    @(negedge clk);
    bus.modo_auto = 1'b1;
    c0 = cyc;
    expect_step(1, c0 + 13);
    expect_step(1, c0 + 23);
    expect_step(1, c0 + 33);
    // Previous-button event collides with the tick at c0+43; timer restarts.
    while (cyc < c0 + 36) @(negedge clk);
    expect_step(-1, c0 + 43);
    expect_step(1, c0 + 53);
    bus.botoes = 2'b10;
    repeat (8) @(negedge clk);
    bus.botoes = 2'b00;
    while (cyc < c0 + 55) @(negedge clk);
    check("auto_quadro", {61'd0, bus.quadro}, 64'd0);
    bus.modo_auto = 1'b0;
    repeat (40) @(negedge clk);
    check("manual_stop_quadro", {61'd0, bus.quadro}, 64'd0);
    check("auto_sb_drained", 64'(sb.size()), 64'd0);

    // Button held across reset is a fresh press once reset releases.
    pulse(2'b01, 8, 8, 1);
    check("pre_rst_quadro", {61'd0, bus.quadro}, 64'd1);
    @(negedge clk);
    bus.botoes = 2'b01;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("held_rst_quadro", {61'd0, bus.quadro}, 64'd0);
    check("held_rst_padrao", {29'd0, bus.padrao}, 64'h1F);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_q = 3'd0;
    expect_step(1, cyc + LAT);
    repeat (10) @(negedge clk);
    bus.botoes = 2'b00;
    repeat (12) @(negedge clk);
    check("held_quadro", {61'd0, bus.quadro}, 64'd1);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seletor_quadros.md
Name: seletor_quadros

Overview:
- Upstream frame source for the 7x5 LED matrix scanner.
- Debounces two push-buttons and steps a 3-bit frame index forward or backward, with wrap-around.
- Optional auto-play mode advances the frame on a timer.
- Outputs the current frame index plus a registered 35-bit bitmap, which the scanner consumes row by row.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a button level (20 ms at 50 MHz).
- AUTO_PERIOD, 25000000, cycles between auto-play advances (0.5 s at 50 MHz).

Ports:
- clock_50MHz  input  1  system clock. This is the only clock.
- reset  input  1  reset, asynchronous and active-high.
- botoes  input  2  raw push-buttons, 1 = pressed; [0] = next frame, [1] = previous frame.
- modo_auto  input  1  slide switch; 1 = auto-play, 0 = manual.
- quadro  output  3  current frame index, 0..7.
- padrao  output  35  bitmap of current frame; bit (linha*5 + coluna) is the LED, 1 = on.
- novo_quadro  output  1  one-cycle pulse, high in the first cycle a new quadro/padrao is presented.

Behaviour:
- Reset values (asynchronous):
  - quadro = 0.
  - padrao = 35'h000_0001F (row 0 lit).
  - novo_quadro = 0.
  - Synchronizers, debounced levels, debounce counters and auto timer all = 0.
  - FSM = MANUAL.
- Input synchronizer: each botoes bit passes through 2 flip-flops before any other logic.
- Debouncer, per button:
  - Counter increments while the synchronized level differs from the debounced level; it clears whenever they are equal.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized value and the counter clears.
  - A pulse shorter than DEBOUNCE_CYCLES cycles is ignored.
- Press event:
  - A 0->1 transition of the debounced level produces a one-cycle event (ev_prox, ev_ant).
  - A release produces no event.
- Latency: raw press held steady -> quadro updates on clock edge DEBOUNCE_CYCLES+3 after the raw rising edge.
- Frame update rules:
  - ev_prox only: quadro = quadro+1 mod 8; 7 -> 0.
  - ev_ant only: quadro = quadro-1 mod 8; 0 -> 7.
  - ev_prox and ev_ant in the same cycle: no change, no novo_quadro.
- FSM states:
  - MANUAL: timer held at 0.
  - AUTO: timer counts 0..AUTO_PERIOD-1. At the terminal count it wraps to 0 and issues tick_auto, which is equivalent to ev_prox.
  - Transitions: MANUAL -> AUTO when synchronized modo_auto = 1; AUTO -> MANUAL when it = 0. Both transitions clear the timer.
  - modo_auto has a 2-FF synchronizer and no debounce.
- Button events in AUTO:
  - Buttons remain active.
  - Any accepted button event restarts the timer at 0.
  - If a button event and tick_auto fall in the same cycle, the button wins: the tick is discarded and only the button step is applied.
  - If both buttons fire in the same cycle in AUTO, the events cancel, but the timer still restarts.
- padrao:
  - Registered, and updated on the same edge as quadro, so the two are never mismatched.
  - Frame k, for k = 0..6: row k fully lit, i.e. bits 5k..5k+4 = 1, all others 0.
  - Frame 7: all 35 bits = 1.
- novo_quadro: asserted exactly in the cycle after the edge that changed quadro; at most one cycle wide per change.
- Reset mid-operation:
  - All state returns to reset values immediately.
  - A button still held when reset releases is seen as a new press: the debounced level is 0, so after debounce a single event fires.

Test Plan:
Benches use DEBOUNCE_CYCLES=4 and AUTO_PERIOD=10.
- Reset:
  - Stimulus: assert reset asynchronously mid-cycle.
  - Required: quadro=0, padrao=0x000_0001F, novo_quadro=0 without waiting for a clock edge.
  - Stimulus: release reset with botoes=0.
  - Required: outputs hold.
- Next and wrap:
  - Stimulus: press botoes[0] for 8 cycles, 8 times.
  - Required: quadro steps 1,2,...,7,0, with one novo_quadro pulse each. At quadro=7, padrao=all ones. Each update lands exactly 7 edges after the raw press.
- Previous and bounce:
  - Stimulus: from quadro=0, press botoes[1] steadily.
  - Required: quadro=7.
  - Stimulus: pulse botoes[1] high for 3 cycles, low for 3 cycles, 3 times.
  - Required: no change, no novo_quadro.
- Simultaneous press:
  - Stimulus: from quadro=3, raise both buttons on the same cycle and hold.
  - Required: quadro stays 3, no novo_quadro.
  - Stimulus: release both, then press botoes[0] alone.
  - Required: quadro=4.
- Auto-play:
  - Stimulus: modo_auto=1 from quadro=5.
  - Required: quadro advances to 6, 7, 0 at 10-cycle intervals.
  - Stimulus: land a botoes[1] event on the terminal-count cycle.
  - Required: quadro decrements only, and the next auto advance comes 10 cycles later.
  - Stimulus: modo_auto=0.
  - Required: advancing stops.
- Reset while held:
  - Stimulus: hold botoes[0], assert reset for 2 cycles, release reset.
  - Required: quadro=0, then a single advance to 1 exactly 7 edges after reset deasserts.
